// File: rtl/snake_pkg.sv
// -----------------------------------------------------------------------------
// snake_pkg
//   Shared definitions for the snake direction path: the direction encoding,
//   the button bit positions of the debounced button bus, and a helper that
//   returns the opposite direction.
// -----------------------------------------------------------------------------
package snake_pkg;

    localparam int unsigned DIR_W = 2;
    localparam int unsigned BTN_W = 4;

    typedef logic [DIR_W-1:0] dir_t;

    // Direction encoding; opposite directions differ only in bit 0
    localparam dir_t DIR_UP    = 2'b00;
    localparam dir_t DIR_DOWN  = 2'b01;
    localparam dir_t DIR_LEFT  = 2'b10;
    localparam dir_t DIR_RIGHT = 2'b11;

    // Bit positions inside the button bus
    localparam int unsigned BTN_UP    = 0;
    localparam int unsigned BTN_DOWN  = 1;
    localparam int unsigned BTN_LEFT  = 2;
    localparam int unsigned BTN_RIGHT = 3;

    // Opposite direction: UP<->DOWN, LEFT<->RIGHT
    function automatic dir_t f_Opposite(input dir_t d);
        return d ^ dir_t'(2'b01);
    endfunction

endpackage

// File: rtl/snake_dir_fifo.sv
// -----------------------------------------------------------------------------
// snake_dir_fifo
//   Generic synchronous FIFO used to buffer direction commands.
//   A push while full is accepted only when a pop happens on the same edge.
//   A pop while empty is ignored.
//
// Parameters
//   c_DEPTH  number of entries (power of 2, >= 2)
//   c_WIDTH  entry width
// Ports
//   i_Clk    clock
//   i_Rst_n  asynchronous active-low reset (clears contents and pointers)
//   i_Push   write i_Data at the tail
//   i_Data   data to write
//   i_Pop    remove the head entry
//   o_Full   all entries occupied
//   o_Empty  no entries occupied
//   o_Head   oldest entry (registered storage)
//   o_Last   newest entry (registered storage)
// -----------------------------------------------------------------------------
module snake_dir_fifo #(
    parameter int unsigned c_DEPTH = 2,
    parameter int unsigned c_WIDTH = 2
) (
    input  logic               i_Clk,
    input  logic               i_Rst_n,
    input  logic               i_Push,
    input  logic [c_WIDTH-1:0] i_Data,
    input  logic               i_Pop,
    output logic               o_Full,
    output logic               o_Empty,
    output logic [c_WIDTH-1:0] o_Head,
    output logic [c_WIDTH-1:0] o_Last
);

    localparam int unsigned PTR_W = (c_DEPTH > 1) ? $clog2(c_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [c_WIDTH-1:0] mem_q [c_DEPTH];
    logic [c_WIDTH-1:0] mem_d [c_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q,  count_d;
    logic               push_ok;
    logic               pop_ok;

    assign o_Empty = (count_q == CNT_W'(0));
    assign o_Full  = (count_q == CNT_W'(c_DEPTH));

    // A full FIFO still takes a push when the head leaves on the same edge
    assign pop_ok  = i_Pop & ~o_Empty;
    assign push_ok = i_Push & (~o_Full | pop_ok);

    // Next-state for storage, pointers and occupancy
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (push_ok) begin
            mem_d[wr_ptr_q] = i_Data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign o_Head = mem_q[rd_ptr_q];
    // Newest entry sits one slot behind the write pointer (wraps naturally)
    assign o_Last = mem_q[wr_ptr_q - PTR_W'(1)];

endmodule

// File: rtl/snake_direction_queue.sv
// -----------------------------------------------------------------------------
// snake_direction_queue
//   Turns rising edges of the debounced direction buttons into 2-bit snake
//   direction commands, buffers them in a small FIFO and hands them to the
//   game engine over a valid/ready handshake.
//
//   Optional feature macro: SNAKE_DIR_REVERSAL_FILTER_EN
//     defined   - a press equal to, or opposite of, the reference direction
//                 (newest queued command, else the current direction) is
//                 silently discarded.
//     undefined - every priority-winning press is queued; the engine is
//                 responsible for reversal/duplicate handling.
//
// Parameters
//   c_DEPTH     FIFO entries (power of 2, >= 2)
//   c_INIT_DIR  o_Cur_Dir value after reset
// Ports
//   i_Clk        system clock
//   i_Rst_n      asynchronous active-low reset
//   i_Buttons    debounced levels [0]=UP [1]=DOWN [2]=LEFT [3]=RIGHT
//   o_Dir_Valid  FIFO head valid
//   o_Dir        FIFO head direction
//   i_Dir_Ready  engine consumes the head when o_Dir_Valid & i_Dir_Ready
//   o_Cur_Dir    last consumed direction
//   o_Overflow   one-cycle pulse: accepted press dropped because FIFO full
// -----------------------------------------------------------------------------
module snake_direction_queue
    import snake_pkg::*;
#(
    parameter int unsigned c_DEPTH    = 2,
    parameter logic [1:0]  c_INIT_DIR = 2'b11
) (
    input  logic             i_Clk,
    input  logic             i_Rst_n,
    input  logic [BTN_W-1:0] i_Buttons,
    output logic             o_Dir_Valid,
    output logic [DIR_W-1:0] o_Dir,
    input  logic             i_Dir_Ready,
    output logic [DIR_W-1:0] o_Cur_Dir,
    output logic             o_Overflow
);

    logic [BTN_W-1:0] prev_q;
    logic [BTN_W-1:0] rise;
    logic             cand_valid;
    dir_t             cand_dir;
    logic             accept;
    logic             pop;
    dir_t             cur_dir_q, cur_dir_d;
    logic             overflow_q, overflow_d;
    logic             fifo_full;
    logic             fifo_empty;
    dir_t             fifo_head;
`ifdef SNAKE_DIR_REVERSAL_FILTER_EN
    dir_t             fifo_last;
    dir_t             ref_dir;
`endif

    // Previous levels reset high so buttons held through reset never count
    assign rise = i_Buttons & ~prev_q;

    // Priority encoder: UP > DOWN > LEFT > RIGHT; losers are dropped
    always_comb begin
        cand_valid = 1'b0;
        cand_dir   = DIR_UP;
        if (rise[BTN_UP]) begin
            cand_valid = 1'b1;
            cand_dir   = DIR_UP;
        end else if (rise[BTN_DOWN]) begin
            cand_valid = 1'b1;
            cand_dir   = DIR_DOWN;
        end else if (rise[BTN_LEFT]) begin
            cand_valid = 1'b1;
            cand_dir   = DIR_LEFT;
        end else if (rise[BTN_RIGHT]) begin
            cand_valid = 1'b1;
            cand_dir   = DIR_RIGHT;
        end
    end

`ifdef SNAKE_DIR_REVERSAL_FILTER_EN
    // Compare against the direction the snake will have when this command
    // is reached: newest queued entry, otherwise the current direction.
    assign ref_dir = fifo_empty ? cur_dir_q : fifo_last;
    assign accept  = cand_valid
                   & (cand_dir != ref_dir)
                   & (cand_dir != f_Opposite(ref_dir));
`else
    assign accept  = cand_valid;
`endif

    // Head only consumable once it is visible
    assign pop = ~fifo_empty & i_Dir_Ready;

    // Next-state for the current direction and overflow pulse
    always_comb begin
        cur_dir_d  = cur_dir_q;
        overflow_d = 1'b0;
        if (pop) begin
            cur_dir_d = fifo_head;
        end
        if (accept && fifo_full && !pop) begin
            overflow_d = 1'b1;
        end
    end

    // Registers
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            prev_q     <= '1;
            cur_dir_q  <= c_INIT_DIR;
            overflow_q <= 1'b0;
        end else begin
            prev_q     <= i_Buttons;
            cur_dir_q  <= cur_dir_d;
            overflow_q <= overflow_d;
        end
    end

    snake_dir_fifo #(
        .c_DEPTH (c_DEPTH),
        .c_WIDTH (DIR_W)
    ) u_fifo (
        .i_Clk   (i_Clk),
        .i_Rst_n (i_Rst_n),
        .i_Push  (accept),
        .i_Data  (cand_dir),
        .i_Pop   (pop),
        .o_Full  (fifo_full),
        .o_Empty (fifo_empty),
        .o_Head  (fifo_head),
`ifdef SNAKE_DIR_REVERSAL_FILTER_EN
        .o_Last  (fifo_last)
`else
        .o_Last  ()
`endif
    );

    assign o_Dir_Valid = ~fifo_empty;
    assign o_Dir       = fifo_head;
    assign o_Cur_Dir   = cur_dir_q;
    assign o_Overflow  = overflow_q;

endmodule

// File: tb/tb_snake_direction_queue.sv
// -----------------------------------------------------------------------------
// tb_snake_direction_queue
//   Self-checking bench for snake_direction_queue. Expected directions are
//   queued when a press is driven and compared as the engine side consumes
//   them. Expectations follow SNAKE_DIR_REVERSAL_FILTER_EN when defined.
// -----------------------------------------------------------------------------
module tb_snake_direction_queue;

    logic       clk;
    logic       rst_n;
    logic [3:0] buttons;
    logic       dir_valid;
    logic [1:0] dir;
    logic       dir_ready;
    logic [1:0] cur_dir;
    logic       overflow;

    int         n_pass;
    int         n_total;
    logic [1:0] exp_q[$];
    logic [1:0] exp_d;
    logic [1:0] last_d;
    int         budget;

    localparam logic [1:0] UP    = 2'b00;
    localparam logic [1:0] DOWN  = 2'b01;
    localparam logic [1:0] LEFT  = 2'b10;
    localparam logic [1:0] RIGHT = 2'b11;

    snake_direction_queue #(
        .c_DEPTH    (2),
        .c_INIT_DIR (2'b11)
    ) dut (
        .i_Clk       (clk),
        .i_Rst_n     (rst_n),
        .i_Buttons   (buttons),
        .o_Dir_Valid (dir_valid),
        .o_Dir       (dir),
        .i_Dir_Ready (dir_ready),
        .o_Cur_Dir   (cur_dir),
        .o_Overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] m);
        buttons = m;
        tick();
        buttons = 4'b0000;
        tick();
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        buttons   = 4'b0000;
        dir_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        exp_q.delete();
    endtask

    // Drain the scoreboard through the handshake; inlined checks per test
    task automatic test_reset();
        rst_n     = 1'b0;
        buttons   = 4'b0001;
        dir_ready = 1'b0;
        tick();
        tick();
        n_total++; if (dir_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", dir_valid); else n_pass++;
        n_total++; if (dir !== 2'b00) $display("FAIL reset_dir: got %b expected 00", dir); else n_pass++;
        n_total++; if (cur_dir !== RIGHT) $display("FAIL reset_cur_dir: got %b expected 11", cur_dir); else n_pass++;
        n_total++; if (overflow !== 1'b0) $display("FAIL reset_overflow: got %b expected 0", overflow); else n_pass++;
        rst_n = 1'b1;
        repeat (3) tick();
        n_total++; if (dir_valid !== 1'b0) $display("FAIL held_at_reset: got valid %b expected 0", dir_valid); else n_pass++;
        buttons = 4'b0000;
        tick();
        exp_q.push_back(UP);
        buttons = 4'b0001;
        tick();
        n_total++; if (dir_valid !== 1'b1 || dir !== UP) $display("FAIL t1_push: got valid %b dir %b expected 1 00", dir_valid, dir); else n_pass++;
        repeat (2) tick();
        buttons = 4'b0000;
        tick();
        budget = 20; dir_ready = 1'b1; last_d = cur_dir;
        while (exp_q.size() != 0 && budget != 0) begin
            if (dir_valid) begin
                exp_d = exp_q.pop_front(); last_d = exp_d;
                n_total++; if (dir !== exp_d) $display("FAIL t1_head: got %b expected %b", dir, exp_d); else n_pass++;
            end
            tick(); budget--;
        end
        dir_ready = 1'b0;
        n_total++; if (exp_q.size() != 0 || dir_valid !== 1'b0) $display("FAIL t1_drain: got valid %b left %0d expected 0 0", dir_valid, exp_q.size()); else n_pass++;
        n_total++; if (cur_dir !== last_d) $display("FAIL t1_cur_dir: got %b expected %b", cur_dir, last_d); else n_pass++;
    endtask

    task automatic test_filter();
        do_reset();
        press(4'b0100);
`ifdef SNAKE_DIR_REVERSAL_FILTER_EN
        n_total++; if (dir_valid !== 1'b0) $display("FAIL t2_reverse: got valid %b expected 0", dir_valid); else n_pass++;
`else
        exp_q.push_back(LEFT);
        n_total++; if (dir_valid !== 1'b1 || dir !== LEFT) $display("FAIL t2_reverse: got valid %b dir %b expected 1 10", dir_valid, dir); else n_pass++;
`endif
        exp_q.push_back(UP);
        buttons = 4'b0001;
        tick();
        n_total++; if (dir_valid !== 1'b1 || dir !== exp_q[0]) $display("FAIL t2_up: got valid %b dir %b expected 1 %b", dir_valid, dir, exp_q[0]); else n_pass++;
        buttons = 4'b0000;
        tick();
        budget = 20; dir_ready = 1'b1; last_d = cur_dir;
        while (exp_q.size() != 0 && budget != 0) begin
            if (dir_valid) begin
                exp_d = exp_q.pop_front(); last_d = exp_d;
                n_total++; if (dir !== exp_d) $display("FAIL t2_head: got %b expected %b", dir, exp_d); else n_pass++;
            end
            tick(); budget--;
        end
        dir_ready = 1'b0;
        n_total++; if (exp_q.size() != 0 || dir_valid !== 1'b0) $display("FAIL t2_drain: got valid %b left %0d expected 0 0", dir_valid, exp_q.size()); else n_pass++;
        n_total++; if (cur_dir !== last_d) $display("FAIL t2_cur_dir: got %b expected %b", cur_dir, last_d); else n_pass++;
    endtask

    task automatic test_priority();
        do_reset();
        exp_q.push_back(DOWN);
        buttons = 4'b0110;
        tick();
        n_total++; if (dir_valid !== 1'b1 || dir !== DOWN) $display("FAIL t3_priority: got valid %b dir %b expected 1 01", dir_valid, dir); else n_pass++;
        buttons = 4'b0000;
        tick();
        budget = 20; dir_ready = 1'b1; last_d = cur_dir;
        while (exp_q.size() != 0 && budget != 0) begin
            if (dir_valid) begin
                exp_d = exp_q.pop_front(); last_d = exp_d;
                n_total++; if (dir !== exp_d) $display("FAIL t3_head: got %b expected %b", dir, exp_d); else n_pass++;
            end
            tick(); budget--;
        end
        dir_ready = 1'b0;
        n_total++; if (exp_q.size() != 0 || dir_valid !== 1'b0) $display("FAIL t3_single: got valid %b left %0d expected 0 0", dir_valid, exp_q.size()); else n_pass++;
        n_total++; if (cur_dir !== last_d) $display("FAIL t3_cur_dir: got %b expected %b", cur_dir, last_d); else n_pass++;
    endtask

    task automatic test_overflow();
        do_reset();
        exp_q.push_back(UP);
        press(4'b0001);
        exp_q.push_back(LEFT);
        press(4'b0100);
        n_total++; if (overflow !== 1'b0) $display("FAIL t4_no_early_ovf: got %b expected 0", overflow); else n_pass++;
        buttons = 4'b0010;
        tick();
        n_total++; if (overflow !== 1'b1) $display("FAIL t4_overflow: got %b expected 1", overflow); else n_pass++;
        n_total++; if (dir_valid !== 1'b1 || dir !== UP) $display("FAIL t4_head_stable: got valid %b dir %b expected 1 00", dir_valid, dir); else n_pass++;
        buttons = 4'b0000;
        tick();
        n_total++; if (overflow !== 1'b0) $display("FAIL t4_pulse_width: got %b expected 0", overflow); else n_pass++;
        budget = 20; dir_ready = 1'b1; last_d = cur_dir;
        while (exp_q.size() != 0 && budget != 0) begin
            if (dir_valid) begin
                exp_d = exp_q.pop_front(); last_d = exp_d;
                n_total++; if (dir !== exp_d) $display("FAIL t4_head: got %b expected %b", dir, exp_d); else n_pass++;
            end
            tick(); budget--;
        end
        dir_ready = 1'b0;
        n_total++; if (exp_q.size() != 0 || dir_valid !== 1'b0) $display("FAIL t4_drain: got valid %b left %0d expected 0 0", dir_valid, exp_q.size()); else n_pass++;
        n_total++; if (cur_dir !== last_d) $display("FAIL t4_cur_dir: got %b expected %b", cur_dir, last_d); else n_pass++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        exp_q.push_back(UP);
        press(4'b0001);
        exp_q.push_back(LEFT);
        press(4'b0100);
        // Full: pop head and push DOWN on the same edge
        exp_d = exp_q.pop_front();
        n_total++; if (dir !== exp_d) $display("FAIL t5_head_before: got %b expected %b", dir, exp_d); else n_pass++;
        exp_q.push_back(DOWN);
        buttons   = 4'b0010;
        dir_ready = 1'b1;
        tick();
        dir_ready = 1'b0;
        buttons   = 4'b0000;
        n_total++; if (overflow !== 1'b0) $display("FAIL t5_no_overflow: got %b expected 0", overflow); else n_pass++;
        n_total++; if (cur_dir !== UP) $display("FAIL t5_cur_dir: got %b expected 00", cur_dir); else n_pass++;
        n_total++; if (dir_valid !== 1'b1 || dir !== LEFT) $display("FAIL t5_new_head: got valid %b dir %b expected 1 10", dir_valid, dir); else n_pass++;
        tick();
        budget = 20; dir_ready = 1'b1; last_d = cur_dir;
        while (exp_q.size() != 0 && budget != 0) begin
            if (dir_valid) begin
                exp_d = exp_q.pop_front(); last_d = exp_d;
                n_total++; if (dir !== exp_d) $display("FAIL t5_head: got %b expected %b", dir, exp_d); else n_pass++;
            end
            tick(); budget--;
        end
        dir_ready = 1'b0;
        n_total++; if (exp_q.size() != 0 || dir_valid !== 1'b0) $display("FAIL t5_drain: got valid %b left %0d expected 0 0", dir_valid, exp_q.size()); else n_pass++;
        n_total++; if (cur_dir !== last_d) $display("FAIL t5_cur_dir_end: got %b expected %b", cur_dir, last_d); else n_pass++;
    endtask

    task automatic test_async_reset();
        do_reset();
        press(4'b0001);
        dir_ready = 1'b1;
        tick();
        dir_ready = 1'b0;
        n_total++; if (cur_dir !== UP) $display("FAIL t6_pre_cur_dir: got %b expected 00", cur_dir); else n_pass++;
        press(4'b0100);
        n_total++; if (dir_valid !== 1'b1) $display("FAIL t6_pre_valid: got %b expected 1", dir_valid); else n_pass++;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        n_total++; if (dir_valid !== 1'b0) $display("FAIL t6_async_valid: got %b expected 0", dir_valid); else n_pass++;
        n_total++; if (cur_dir !== RIGHT) $display("FAIL t6_async_cur_dir: got %b expected 11", cur_dir); else n_pass++;
        n_total++; if (dir !== 2'b00) $display("FAIL t6_async_dir: got %b expected 00", dir); else n_pass++;
        tick();
        rst_n = 1'b1;
        tick();
        exp_q.delete();
        n_total++; if (dir_valid !== 1'b0 || overflow !== 1'b0) $display("FAIL t6_after: got valid %b ovf %b expected 0 0", dir_valid, overflow); else n_pass++;
    endtask

    initial begin
        n_pass    = 0;
        n_total   = 0;
        rst_n     = 1'b0;
        buttons   = 4'b0000;
        dir_ready = 1'b0;
        test_reset();
        test_filter();
        test_priority();
        test_overflow();
        test_back_to_back();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
